spi_frame_writer: RTL and testbench

//  SPI target that takes pixel data from the MCU and writes it into the LED-matrix framebuffer.

---
 rtl/pixel_pkg.sv | 27 ++
 rtl/spi_byte_rx.sv | 78 +++++++
 rtl/spi_frame_writer.sv | 191 +++++++++++++++++++
 tb/tb_spi_frame_writer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and default geometry for the LED-matrix framebuffer write path.
package pixel_pkg;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 3;
  localparam int DEPTH       = 2048;
  localparam int SYNC_STAGES = 2;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [7:0] {
    CMD_WRITE = 8'h01,
    CMD_CLEAR = 8'h02,
    CMD_SWAP  = 8'h03
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    CLEAR,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the pins into clk, detects edges and
// assembles MSB-first bytes. A low chip enable discards any partial byte.
module spi_byte_rx
  import pixel_pkg::*;
#(
  parameter int SYNC_STAGES = pixel_pkg::SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       sdi,
  input  logic       ce,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       ce_rise,
  output logic       ce_fall,
  output logic       sclk_fall,
  output logic       ce_level
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] ce_sync;
  logic                   sclk_d;
  logic                   ce_d;
  logic [6:0]             shreg;
  logic [2:0]             bit_cnt;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   sclk_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign ce_level  = ce_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ce_rise   = ce_level & ~ce_d;
  assign ce_fall   = ~ce_level & ce_d;

  // sdi goes through the same depth as sclk so the sampled bit stays aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      ce_sync   <= '0;
      sclk_d    <= 1'b0;
      ce_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], ce};
      sclk_d    <= sclk_s;
      ce_d      <= ce_level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (!ce_level) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shreg   <= {shreg[5:0], sdi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, sdi_s};
        end
      end
    end
  end

endmodule

// File: rtl/spi_frame_writer.sv
// SPI target writing MCU pixel data into the framebuffer: command FSM, address
// counter and CLEAR sweep. Optional status readback on sdo with SPI_STATUS_EN.
module spi_frame_writer
  import pixel_pkg::*;
#(
  parameter int ADDR_W      = pixel_pkg::ADDR_W,
  parameter int DATA_W      = pixel_pkg::DATA_W,
  parameter int DEPTH       = pixel_pkg::DEPTH,
  parameter int SYNC_STAGES = pixel_pkg::SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdi,
  input  logic              ce,
  output logic              sdo,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_swap,
  output logic              busy
);

  // Framebuffer port: wr_en is a plain strobe with no ready; the memory takes
  // wr_addr/wr_data on every clk where wr_en is high, including back-to-back.
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              ce_rise;
  logic              ce_fall;
  logic              sclk_fall;
  logic              ce_level;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-9:0] addr_hi_q;
  logic [ADDR_W-1:0] addr_inc;
  logic              at_top;
  logic              byte_ok;

  logic              wr_en_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              busy_d;
  logic              swap_d;
  logic              load_hi;
  logic              load_lo;
  logic              step_addr;
  logic              clear_start;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .ce        (ce),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .ce_rise   (ce_rise),
    .ce_fall   (ce_fall),
    .sclk_fall (sclk_fall),
    .ce_level  (ce_level)
  );

  // A byte completing on the same clk as ce falling belongs to no transaction.
  assign byte_ok  = byte_valid & ~ce_fall;
  assign at_top   = (addr_q == ADDR_W'(DEPTH - 1));
  assign addr_inc = at_top ? '0 : addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ce_rise) state_d = CMD;
      CMD: begin
        if (ce_fall) begin
          state_d = IDLE;
        end else if (byte_ok) begin
          case (byte_data)
            CMD_WRITE: state_d = ADDR_HI;
            CMD_CLEAR: state_d = CLEAR;
            default:   state_d = IGNORE;
          endcase
        end
      end
      ADDR_HI: begin
        if (ce_fall)      state_d = IDLE;
        else if (byte_ok) state_d = ADDR_LO;
      end
      ADDR_LO: begin
        if (ce_fall)      state_d = IDLE;
        else if (byte_ok) state_d = DATA;
      end
      DATA:   if (ce_fall) state_d = IDLE;
      // The sweep runs to completion regardless of ce.
      CLEAR:  if (at_top) state_d = ce_level ? IGNORE : IDLE;
      IGNORE: if (ce_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d     = 1'b0;
    wr_data_d   = '0;
    busy_d      = 1'b0;
    swap_d      = 1'b0;
    load_hi     = 1'b0;
    load_lo     = 1'b0;
    step_addr   = 1'b0;
    clear_start = 1'b0;
    unique case (state_q)
      CMD: begin
        if (byte_ok) begin
          swap_d      = (byte_data == CMD_SWAP);
          clear_start = (byte_data == CMD_CLEAR);
        end
      end
      ADDR_HI: load_hi = byte_ok;
      ADDR_LO: load_lo = byte_ok;
      DATA: begin
        if (byte_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = byte_data[DATA_W-1:0];
          step_addr = 1'b1;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        step_addr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_swap <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= wr_en_d;
      wr_addr    <= wr_en_d ? addr_q : '0;
      wr_data    <= wr_data_d;
      frame_swap <= swap_d;
      busy       <= busy_d;
    end
  end

  // Address bits above ADDR_W in the big-endian start address are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      addr_hi_q <= '0;
    end else begin
      if (load_hi) addr_hi_q <= byte_data[ADDR_W-9:0];
      if (clear_start)    addr_q <= '0;
      else if (load_lo)   addr_q <= {addr_hi_q, byte_data};
      else if (step_addr) addr_q <= addr_inc;
    end
  end

`ifdef SPI_STATUS_EN
  logic [6:0] frames_swapped;
  logic [7:0] status_sh;

  // Status is latched at ce rise so bit 7 is on sdo before the first sclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_swapped <= '0;
      status_sh      <= '0;
    end else begin
      if (swap_d) frames_swapped <= frames_swapped + 7'd1;
      if (state_q == IDLE && ce_rise)        status_sh <= {busy, frames_swapped};
      else if (state_q == CMD && sclk_fall)  status_sh <= {status_sh[6:0], 1'b0};
    end
  end

  assign sdo = (state_q == CMD) && ce_level && status_sh[7];
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_writer.sv
// Directed bench for spi_frame_writer: vector table of SPI transactions plus
// hand-written CLEAR, partial-byte, status and reset sequences.
`timescale 1ns/1ps
module tb_spi_frame_writer;
  import pixel_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;
  localparam int EW = AW + DW;
  localparam int NV = 7;
`ifdef SPI_STATUS_EN
  localparam logic [7:0] EXP_STATUS = 8'h02;
`else
  localparam logic [7:0] EXP_STATUS = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          sdi = 1'b0;
  logic          ce = 1'b0;
  logic          sdo;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_swap;
  logic          busy;

  always #5 clk = ~clk;

  spi_frame_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .ce        (ce),
    .sdo       (sdo),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_swap(frame_swap),
    .busy      (busy)
  );

  typedef struct {
    int          n;
    logic [47:0] b;
    int          nw;
    logic [41:0] w;
    int          ns;
  } vec_t;

  vec_t          vt[NV];
  int            vectors = 0;
  int            errors = 0;
  int            cyc = 0;
  int            busy_cnt = 0;
  int            swap_cnt = 0;
  logic [EW-1:0] got_q[$];
  int            stamp_q[$];
  logic [EW-1:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      got_q.push_back({wr_addr, wr_data});
      stamp_q.push_back(cyc);
    end
    if (busy) busy_cnt++;
    if (frame_swap) swap_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      clks(4);
      sclk = 1'b1;
      rx = {rx[6:0], sdo};
      clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic ce_on();
    ce = 1'b1;
    clks(8);
  endtask

  task automatic ce_off();
    clks(4);
    ce = 1'b0;
    sdi = 1'b0;
    clks(16);
  endtask

  task automatic clear_mon();
    got_q.delete();
    stamp_q.delete();
    busy_cnt = 0;
    swap_cnt = 0;
  endtask

  initial begin
    logic [7:0]    rx;
    logic [7:0]    sdo_acc;
    logic [AW-1:0] ia;
    int            t;
    int            bad;
    int            contig;

    vt[0] = '{5, 48'h010005040200, 2, {11'd5, 3'd4, 11'd6, 3'd2, 14'd0}, 0};
    vt[1] = '{5, 48'h0107FF010700, 2, {11'd2047, 3'd1, 11'd0, 3'd7, 14'd0}, 0};
    vt[2] = '{1, 48'h030000000000, 0, 42'd0, 1};
    vt[3] = '{3, 48'hAA0102000000, 0, 42'd0, 0};
    vt[4] = '{4, 48'h010010030000, 1, {11'd16, 3'd3, 28'd0}, 0};
    vt[5] = '{4, 48'h01F802050000, 1, {11'd2, 3'd5, 28'd0}, 0};
    vt[6] = '{6, 48'h0103FF060701, 3, {11'd1023, 3'd6, 11'd1024, 3'd7, 11'd1025, 3'd1}, 0};

    // Reset state.
    clks(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_swap", frame_swap, 0);
    check("rst_busy", busy, 0);
    check("rst_sdo", sdo, 0);
    rst_n = 1'b1;
    clks(4);

    // Status readback after two SWAP transactions.
    clear_mon();
    for (int k = 0; k < 2; k++) begin
      ce_on();
      spi_bits(8'h03, 8, rx);
      ce_off();
    end
    check("swap_pulses", swap_cnt, 2);
    ce_on();
    spi_bits(8'h00, 8, rx);
    ce_off();
    check("status_byte", rx, EXP_STATUS);
    check("sdo_ce_low", sdo, 0);

    // Table-driven transactions.
    for (int v = 0; v < NV; v++) begin
      clear_mon();
      exp_q.delete();
      for (int j = 0; j < vt[v].nw; j++) exp_q.push_back(vt[v].w[41-14*j -: 14]);
      sdo_acc = '0;
      ce_on();
      for (int i = 0; i < vt[v].n; i++) begin
        spi_bits(vt[v].b[47-8*i -: 8], 8, rx);
        if (i > 0) sdo_acc = sdo_acc | rx;
      end
      ce_off();
      check($sformatf("v%0d_count", v), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
        check($sformatf("v%0d_wr%0d", v, j), got_q[j], exp_q[j]);
      check($sformatf("v%0d_swaps", v), swap_cnt, vt[v].ns);
      check($sformatf("v%0d_sdo_data", v), sdo_acc, 0);
    end

    // Partial byte dropped on ce fall, then a clean transaction.
    clear_mon();
    ce_on();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'hFF, 5, rx);
    ce_off();
    check("partial_no_write", got_q.size(), 0);
    ce_on();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h03, 8, rx);
    ce_off();
    check("partial_next_count", got_q.size(), 1);
    check("partial_next_wr", (got_q.size() > 0) ? got_q[0] : {EW{1'b1}}, {11'd16, 3'd3});

    // CLEAR sweep; a WRITE transaction sent while busy must not add writes.
    clear_mon();
    ce_on();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 8, rx);
    ce_off();
    check("clear_busy_mid", busy, 1);
    ce_on();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h05, 8, rx);
    ce_off();
    check("clear_busy_after_tx", busy, 1);
    t = 0;
    while (busy && t < 5000) begin
      clks(1);
      t++;
    end
    check("clear_done", busy, 0);
    clks(10);
    check("clear_count", got_q.size(), 2048);
    bad = -1;
    for (int i = 0; i < got_q.size(); i++) begin
      ia = AW'(i);
      if (bad < 0 && got_q[i] !== {ia, {DW{1'b0}}}) bad = i;
    end
    check("clear_contents_first_bad", bad, -1);
    contig = (stamp_q.size() > 0) ? stamp_q[stamp_q.size()-1] - stamp_q[0] : -1;
    check("clear_contiguous", contig, 2047);
    check("clear_busy_cycles", busy_cnt, 2048);

    // Reset while a DATA write strobe is on the port.
    ce_on();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h05, 7, rx);
    sdi = 1'b1;
    clks(4);
    sclk = 1'b1;
    t = 0;
    while (!wr_en && t < 10) begin
      clks(1);
      t++;
    end
    check("rst_data_strobe_seen", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check("rst_data_wr_en", wr_en, 0);
    check("rst_data_wr_addr", wr_addr, 0);
    check("rst_data_wr_data", wr_data, 0);
    clks(1);
    sclk = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(2);
    clear_mon();
    spi_bits(8'h06, 8, rx);
    ce_off();
    check("rst_data_no_write", got_q.size(), 0);

    // Reset in the middle of a CLEAR sweep.
    ce_on();
    spi_bits(8'h02, 8, rx);
    ce_off();
    clks(50);
    check("rst_clear_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_clear_wr_en", wr_en, 0);
    check("rst_clear_busy", busy, 0);
    clks(4);
    rst_n = 1'b1;
    clear_mon();
    clks(3000);
    check("rst_clear_no_write", got_q.size(), 0);
    check("rst_clear_no_busy", busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
